cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Run-mode sequencer for the single-cycle MIPS core. Sits between the debounced push-buttons, the UART programmer and the core. Owns three things:
- the UART-programmer reset;
- the core reset;
- a one-cycle core clock-enable, giving free-run, single-step and PC-breakpoint halt.

This replaces ad-hoc `inited`/`upg_rst` flops in the top level with one explicit state machine.

## Interface
Parameters:
- `TICK_DIV`, default 20: `clock` cycles per core step in RUN. Legal range is ≥2.
- `CNT_W`, default 32: width of the retired-step counter.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `btn_prog` in 1: debounced level. Rising edge requests UART programming.
- `btn_run` in 1: debounced level. Rising edge requests execution.
- `btn_step` in 1: debounced level. Rising edge requests one core step.
- `step_mode` in 1: switch. 1 means run requests enter STEP instead of RUN.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in 32: breakpoint PC.
- `pc` in 32: current core PC.
- `upg_done` in 1: UART programmer finished.
- `upg_rst` out 1: active-high hold of the UART programmer.
- `cpu_rst` out 1: active-high core reset.
- `cpu_ce` out 1: core clock-enable, one-cycle pulse per step.
- `state` out 3: current state encoding, for LED display.
- `step_cnt` out `CNT_W`: number of `cpu_ce` pulses since the core left reset.

## Operation
States and encodings: IDLE=0, PROG=1, LOADED=2, RUN=3, STEP=4, HALT=5.

Button edges:
- Each button has its own rising-edge detector.
- Edge priority when several edges occur in the same cycle: prog > run > step. Lower-priority edges in that cycle are dropped.
- `go_state` means RUN if `step_mode`=0, otherwise STEP.

Outputs by state:
- `upg_rst` = 0 only in PROG; 1 in every other state.
- `cpu_rst` = 1 in IDLE, PROG and LOADED; 0 in RUN, STEP and HALT.

Transitions:
- IDLE:
  - prog edge → PROG.
  - run edge → `go_state` (executes the existing memory image).
- PROG:
  - `upg_done`=1 → LOADED.
  - run and step edges are ignored.
  - prog edge is ignored (already programming).
- LOADED:
  - run edge → `go_state`.
  - prog edge → PROG.
- RUN:
  - Each tick issues one `cpu_ce`.
  - At a tick with `bp_en`=1 and `pc`==`bp_addr`, go to HALT and issue no `cpu_ce` for that tick.
  - `step_mode`=1 → STEP.
  - prog edge → PROG.
- STEP:
  - step edge → one `cpu_ce`, remain in STEP.
  - run edge with `step_mode`=0 → RUN.
  - prog edge → PROG.
  - The breakpoint is not checked in STEP.
- HALT:
  - run edge → `go_state`. The breakpoint check is masked for the first tick after leaving HALT, so execution proceeds past the breakpoint.
  - step edge → one `cpu_ce`, then STEP.
  - prog edge → PROG.

Counters:
- The tick counter runs only in RUN.
- It is cleared to 0 on every entry to RUN.
- A tick occurs when the count equals `TICK_DIV`-1; the count then wraps to 0.
- `step_cnt` increments on each `cpu_ce`, saturates at all-ones, and clears while `cpu_rst`=1.

## Timing
Reset values (driven by synchronous `reset`, which has highest priority over all events):
- `state`=IDLE, `upg_rst`=1, `cpu_rst`=1, `cpu_ce`=0, `step_cnt`=0, tick counter 0.
- All edge-detector history flops = 0, so a button already held at reset release produces no edge.

Latencies:
- A button first sampled high in cycle n produces its edge in cycle n. The new state is visible from cycle n+1.
- `upg_rst` and `cpu_rst` are combinational decodes of `state`, so they change in the same cycle as `state`.
- `cpu_ce` is registered:
  - RUN: a tick in cycle t gives `cpu_ce`=1 in t+1.
  - STEP/HALT: a step edge in cycle n gives `cpu_ce`=1 in n+1.
  - RUN entered at cycle e gives the first `cpu_ce` at e+`TICK_DIV`.

Boundary conditions:
- `cpu_ce` never asserts while `cpu_rst`=1.
- A pending `cpu_ce` is cancelled if a prog edge arrives in the same cycle.
- Breakpoint compare uses `pc` sampled in the tick cycle.
- `upg_done` already high on entry to PROG moves to LOADED on the next cycle.
- Reset asserted mid-PROG returns to IDLE; `upg_rst` rises in the same cycle as the state change.

## Structure
- Shared package `cpu_ctrl_pkg` holds the state encodings and button-index constants. The top level and the seg/LED display use the same encodings.
- One sub-module, `btn_edge`: a registered rising-edge detector (1-bit level in, 1-cycle pulse out), instantiated three times.
- Everything else is flat in `cpu_run_ctrl`.

## Test plan
- **Reset and programming:** reset, then pulse `btn_prog`.
  - `state` 0→1, with `upg_rst` falling in the same cycle.
  - Raise `upg_done` → `state`=2, `upg_rst`=1, `cpu_rst`=1.
- **Free run:** `TICK_DIV`=4, LOADED, `step_mode`=0, run edge at cycle 10.
  - `state`=3 at cycle 11.
  - `cpu_ce` pulses at cycles 15, 19, 23.
  - `step_cnt`=3 at cycle 24.
- **Breakpoint:** `bp_en`=1, `bp_addr`=0x0000_0010, with `pc` reaching 0x10 at a tick.
  - No `cpu_ce` on that tick; `state`=5.
  - Run edge → the next tick issues `cpu_ce` although `pc`=0x10.
- **Single step:** `step_mode`=1, run edge → `state`=4.
  - Three step edges → exactly three `cpu_ce` pulses, each one cycle after its edge.
  - Holding `btn_step` high gives no extra pulses.
- **Simultaneous edges:** prog and run edges in the same cycle while in RUN.
  - `state`=1, `cpu_rst`=1, no `cpu_ce`, `step_cnt` cleared.
- **Reset mid-operation:** reset asserted during RUN while `btn_run` is held.
  - All outputs return to their reset values.
  - No spurious run edge after reset release.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared run-control encodings: sequencer states and button indices.
// Used by cpu_run_ctrl and the seg/LED display.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PROG   = 3'd1,
    S_LOADED = 3'd2,
    S_RUN    = 3'd3,
    S_STEP   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int BTN_PROG = 0;
  localparam int BTN_RUN  = 1;
  localparam int BTN_STEP = 2;
  localparam int BTN_N    = 3;

  function automatic logic core_in_rst(input state_t s);
    return (s == S_IDLE) || (s == S_PROG) || (s == S_LOADED);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_edge.sv
// btn_edge: registered rising-edge detector for one debounced button.
// Ports: clock, reset (sync, active-high), i_lvl level in, o_edge pulse out.
module btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic i_lvl,
  output logic o_edge
);

  logic r_prev;
  logic r_arm;

  // r_arm stays low for the first cycle after reset so a button
  // already held at release never reads as a fresh press.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_arm  <= 1'b0;
    end else begin
      r_prev <= i_lvl;
      r_arm  <= 1'b1;
    end
  end

  assign o_edge = r_arm & i_lvl & ~r_prev;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-mode sequencer for the MIPS core (prog/run/step/halt).
// Ports: buttons, step_mode, breakpoint, pc, upg_done in; upg_rst,
// cpu_rst, cpu_ce, state, step_cnt out. Sync active-high reset.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 20,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_prog,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             step_mode,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic             upg_done,
  output logic             upg_rst,
  output logic             cpu_rst,
  output logic             cpu_ce,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

  logic [BTN_N-1:0] w_edge;
  logic             w_prog;
  logic             w_run;
  logic             w_step;
  logic             w_tick;
  logic             w_hit;
  logic             w_ce;
  state_t           w_go;
  state_t           w_next;

  state_t           r_state;
  logic [TW-1:0]    r_tcnt;
  logic             r_mask;
  logic             r_ce;
  logic [CNT_W-1:0] r_cnt;

  btn_edge u_prog (
    .clock (clock),
    .reset (reset),
    .i_lvl (btn_prog),
    .o_edge(w_edge[BTN_PROG])
  );

  btn_edge u_run (
    .clock (clock),
    .reset (reset),
    .i_lvl (btn_run),
    .o_edge(w_edge[BTN_RUN])
  );

  btn_edge u_step (
    .clock (clock),
    .reset (reset),
    .i_lvl (btn_step),
    .o_edge(w_edge[BTN_STEP])
  );

  // prog > run > step; losers in the same cycle are dropped
  assign w_prog = w_edge[BTN_PROG];
  assign w_run  = w_edge[BTN_RUN] & ~w_prog;
  assign w_step = w_edge[BTN_STEP] & ~w_prog & ~w_edge[BTN_RUN];

  assign w_go   = step_mode ? S_STEP : S_RUN;
  assign w_tick = (r_state == S_RUN) && (r_tcnt == TLAST);
  assign w_hit  = bp_en && (pc == bp_addr) && !r_mask;

  always_comb begin
    w_next = r_state;
    w_ce   = 1'b0;
    unique case (r_state)
      S_IDLE, S_LOADED: begin
        if (w_prog)     w_next = S_PROG;
        else if (w_run) w_next = w_go;
      end
      S_PROG: begin
        if (upg_done) w_next = S_LOADED;
      end
      S_RUN: begin
        if (w_prog) begin
          w_next = S_PROG;
        end else if (w_tick && w_hit) begin
          w_next = S_HALT;
        end else begin
          w_ce = w_tick;
          if (step_mode) w_next = S_STEP;
        end
      end
      S_STEP: begin
        if (w_prog)                   w_next = S_PROG;
        else if (w_run && !step_mode) w_next = S_RUN;
        else if (w_step)              w_ce   = 1'b1;
      end
      S_HALT: begin
        if (w_prog) begin
          w_next = S_PROG;
        end else if (w_run) begin
          w_next = w_go;
        end else if (w_step) begin
          w_ce   = 1'b1;
          w_next = S_STEP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_mask  <= 1'b0;
      r_ce    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_ce    <= w_ce;
      if (r_state == S_RUN && w_next == S_RUN && !w_tick)
        r_tcnt <= r_tcnt + TW'(1);
      else
        r_tcnt <= '0;
      // resuming from HALT skips the breakpoint for one tick
      if (w_next == S_RUN && r_state != S_RUN)
        r_mask <= (r_state == S_HALT);
      else if (w_tick)
        r_mask <= 1'b0;
      if (core_in_rst(w_next))
        r_cnt <= '0;
      else if (r_ce && !(&r_cnt))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign state    = r_state;
  assign upg_rst  = (r_state != S_PROG);
  assign cpu_rst  = core_in_rst(r_state);
  assign cpu_ce   = r_ce;
  assign step_cnt = r_cnt;

endmodule
